// File: rtl/pwm_pkg.sv
// Shared constants for the PWM timebase: default widths and direction encoding.
package pwm_pkg;
  localparam int   WIDTH_DEF   = 16;
  localparam int   PRESC_W_DEF = 8;
  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM timebase: emits a combinational step every presc_sh+1 enabled cycles.
// presc_sh is shadowed from prescale_i while idle, on period wrap, or on counter clear.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               count_reset_i,
  input  logic               reload_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               step_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] presc_sh_q, presc_sh_d;

  assign step_o = en_i && (presc_cnt_q == presc_sh_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    presc_sh_d  = presc_sh_q;
    if (!en_i || reload_i || count_reset_i) begin
      presc_sh_d = prescale_i;
    end
    if (count_reset_i) begin
      presc_cnt_d = '0;
    end else if (en_i) begin
      presc_cnt_d = step_o ? '0 : presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      presc_sh_q  <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      presc_sh_q  <= presc_sh_d;
    end
  end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: up/down counter between 0 and a shadowed period, advanced by pwm_prescaler.
// count_val and period_done update on the same edge as the step; period_done is a one-clock wrap pulse.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               count_reset,
  input  logic               upnotdown,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   count_val,
  output logic               period_done
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic             done_q, done_d;
  logic             step;
  logic             wrap;
  logic             up;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .count_reset_i (count_reset),
    .reload_i      (wrap),
    .prescale_i    (prescale),
    .step_o        (step)
  );

  assign up = (upnotdown == DIR_UP);
  // >= rather than == so a counter left above the period still wraps.
  assign wrap = step && (up ? (count_q >= period_sh_q) : (count_q == '0));

  always_comb begin
    count_d     = count_q;
    period_sh_d = period_sh_q;
    done_d      = wrap;
    if (!en || wrap) begin
      period_sh_d = period;
    end
    if (step) begin
      if (wrap) begin
        count_d = up ? '0 : period_sh_q;
      end else begin
        count_d = up ? count_q + CNT_ONE : count_q - CNT_ONE;
      end
    end
    if (count_reset) begin
      count_d     = up ? '0 : period;
      done_d      = 1'b0;
      period_sh_d = period;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      period_sh_q <= '0;
      done_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      period_sh_q <= period_sh_d;
      done_q      <= done_d;
    end
  end

  assign count_val   = count_q;
  assign period_done = done_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter: inputs change and outputs are checked on the falling edge.
module tb_pwm_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        count_reset;
  logic        upnotdown;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic [15:0] count_val;
  logic        period_done;

  int checks = 0;
  int errors = 0;

  pwm_counter #(.WIDTH(16), .PRESC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .period      (period),
    .prescale    (prescale),
    .count_val   (count_val),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp_cnt, input logic exp_pd);
    checks++;
    assert (count_val === exp_cnt) else begin
      errors++;
      $error("FAIL %s count_val: observed %0h expected %0h", tag, count_val, exp_cnt);
    end
    checks++;
    assert (period_done === exp_pd) else begin
      errors++;
      $error("FAIL %s period_done: observed %0b expected %0b", tag, period_done, exp_pd);
    end
  endtask

  // One rising edge, then check on the following falling edge.
  task automatic step_chk(input string tag, input logic [15:0] exp_cnt, input logic exp_pd);
    @(negedge clk);
    chk(tag, exp_cnt, exp_pd);
  endtask

  initial begin
    logic [15:0] down_seq [6];
    logic [15:0] shadow_seq [12];
    down_seq   = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd5};
    shadow_seq = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd0,
                   16'd1, 16'd2, 16'd3, 16'd0};

    rst = 1'b1; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
    period = 16'd4; prescale = 8'd0;
    @(negedge clk);
    chk("reset", 16'd0, 1'b0);

    // Up count, period 4, no prescale.
    rst = 1'b0;
    step_chk("idle_load", 16'd0, 1'b0);
    en = 1'b1;
    for (int i = 1; i <= 10; i++)
      step_chk("up_p4", 16'(i % 5), (i % 5) == 0);

    // Prescale 2: one count every 3 clocks, 12-clock period.
    en = 1'b0; count_reset = 1'b1; period = 16'd3; prescale = 8'd2;
    step_chk("creset_up", 16'd0, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 24; k++)
      step_chk("presc2", 16'((k / 3) % 4), (k % 12) == 0);

    // Down count from a count_reset load.
    en = 1'b0; upnotdown = 1'b0; period = 16'd5; prescale = 8'd0; count_reset = 1'b1;
    step_chk("creset_down", 16'd5, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++)
      step_chk("down_p5", down_seq[k], k == 5);

    // Period write mid-period only takes effect after the wrap.
    en = 1'b0; upnotdown = 1'b1; period = 16'd9; count_reset = 1'b1;
    step_chk("creset_p9", 16'd0, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    step_chk("p9_1", 16'd1, 1'b0);
    step_chk("p9_2", 16'd2, 1'b0);
    period = 16'd3;
    for (int k = 0; k < 12; k++)
      step_chk("shadow", shadow_seq[k], (k == 7) || (k == 11));

    // Enable drop holds the count.
    en = 1'b0; period = 16'd9; count_reset = 1'b1;
    step_chk("creset_hold", 16'd0, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 6; k++)
      step_chk("pre_hold", 16'(k), 1'b0);
    en = 1'b0;
    for (int k = 0; k < 10; k++)
      step_chk("hold", 16'd6, 1'b0);
    en = 1'b1;
    step_chk("resume", 16'd7, 1'b0);

    // Asynchronous reset mid-count with prescale 4.
    en = 1'b0; prescale = 8'd4; count_reset = 1'b1;
    step_chk("creset_p4", 16'd0, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 35; k++)
      step_chk("presc4", 16'(k / 5), 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst", 16'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // count_reset coinciding with a wrap wins: no pulse.
    en = 1'b0; upnotdown = 1'b1; period = 16'd2; prescale = 8'd0;
    step_chk("idle_p2", 16'd0, 1'b0);
    en = 1'b1;
    step_chk("p2_1", 16'd1, 1'b0);
    step_chk("p2_2", 16'd2, 1'b0);
    count_reset = 1'b1;
    step_chk("creset_wrap", 16'd0, 1'b0);
    count_reset = 1'b0;
    step_chk("after_creset", 16'd1, 1'b0);

    // Zero period: wraps on every step in both directions.
    en = 1'b0; period = 16'd0; count_reset = 1'b1;
    step_chk("creset_p0", 16'd0, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++)
      step_chk("p0_up", 16'd0, 1'b1);
    upnotdown = 1'b0;
    for (int k = 0; k < 2; k++)
      step_chk("p0_down", 16'd0, 1'b1);

    // All-ones period: down then up through the top of the range.
    en = 1'b0; period = 16'hFFFF; count_reset = 1'b1;
    step_chk("creset_max", 16'hFFFF, 1'b0);
    count_reset = 1'b0; en = 1'b1;
    step_chk("max_down", 16'hFFFE, 1'b0);
    upnotdown = 1'b1;
    step_chk("max_up", 16'hFFFF, 1'b0);
    step_chk("max_wrap", 16'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Timebase counter directly upstream of the PWM generator; produces the `count_val` it compares against `compare1`/`compare2`.
- Counts up or down between 0 and a programmable period, with a programmable clock prescaler.
- Period and prescale values are shadow-buffered so register writes take effect only at a period boundary.
- Emits a one-cycle `period_done` pulse at every wrap, for interrupt and status logic.

Parameters:
- WIDTH, 16, width of counter and period
- PRESC_W, 8, width of prescale value

Ports:
- clk  in  1  peripheral clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  counter enable
- count_reset  in  1  synchronous counter clear pulse
- upnotdown  in  1  1 = count up, 0 = count down
- period  in  WIDTH  period register value
- prescale  in  PRESC_W  clock divide minus one
- count_val  out  WIDTH  current counter value, registered
- period_done  out  1  one-cycle pulse at wrap, registered

Behaviour:
Reset and state:
- Reset is asynchronous, active-high; clock is clk.
- On rst: count_val=0, period_done=0, presc_cnt=0, period_sh=0, presc_sh=0.

Shadow registers:
- While en=0, period_sh<=period and presc_sh<=prescale every cycle.
- While en=1, both reload only in the cycle a wrap occurs, so the new value applies from the next period.

Prescaler:
- Internal presc_cnt (PRESC_W bits) advances when en=1.
- step = en && (presc_cnt == presc_sh). On step, presc_cnt<=0; otherwise presc_cnt+1.
- The counter therefore advances once every presc_sh+1 clocks. presc_sh=0 means step every enabled cycle.

Up mode (upnotdown=1), on step:
- If count_val >= period_sh: count_val<=0 and period_done<=1 (wrap).
- Else count_val<=count_val+1.
- One period = period_sh+1 steps. The >= comparison also covers a counter left above the period after a direction change or a reset load.

Down mode (upnotdown=0), on step:
- If count_val==0: count_val<=period_sh and period_done<=1 (wrap).
- Else count_val<=count_val-1.

Pulse and latency:
- period_done<=0 in every cycle without a wrap, so it is high for exactly one clk.
- count_val and period_done update at the same clock edge as the step. There is no extra pipeline latency.

Direction change:
- Takes effect at the next step. No clear, no pulse.

count_reset (sync, any en):
- presc_cnt<=0, period_done<=0, period_sh<=period, presc_sh<=prescale.
- count_val<=0 if upnotdown=1, else count_val<=period (raw input).
- Overrides a coincident step or wrap.

en=0:
- count_val and presc_cnt hold, period_done=0. Re-enabling resumes from the held values.

Edge cases:
- period_sh=0: up mode wraps every step, count_val stays 0, period_done pulses every step. Down mode behaves the same.
- Arithmetic is modulo 2^WIDTH. Wrap logic prevents overflow except when period_sh=all-ones, where up mode wraps at all-ones.
- rst mid-count returns everything to reset values immediately, without waiting for clk.

Decomposition:
- Shared package pwm_pkg holds:
  - default WIDTH/PRESC_W constants;
  - DIR_UP=1 / DIR_DOWN=0 encoding.
- One sub-module, pwm_prescaler, owns presc_cnt, presc_sh and the step output.
- pwm_counter holds period_sh, count_val, period_done and the wrap logic.

Test Plan:
- Reset then en=1, upnotdown=1, period=4, prescale=0 -> count_val 0,1,2,3,4,0,...; period_done high only in the cycle count_val returns to 0, every 5 clocks.
- upnotdown=1, period=3, prescale=2 -> count_val changes every 3 clocks; one period = 12 clocks; presc_cnt cycles 0,1,2.
- upnotdown=0, period=5, count_reset pulse -> count_val=5, then 4,3,2,1,0,5 with period_done at the reload to 5.
- Running with period=9, write period=3 at count_val=2 -> counts to 9, wraps, next period wraps at 3, not earlier.
- Drop en at count_val=6 for 10 clocks -> count_val holds 6, period_done stays 0. Re-raise en -> continues at 7.
- Assert rst asynchronously mid-count (count_val=7, prescale=4) -> count_val=0 and period_done=0 before the next edge. Simultaneous count_reset and wrap -> count_val=0 (up) with no period_done pulse.
